// File: rtl/niosii_system_sysid_ext.sv
// niosii_system_sysid_ext: Avalon-MM system-ID slave with caps, scratch, atomic-read uptime counter and build-info words
module niosii_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE = 32'h0,
  parameter logic [31:0] TIMESTAMP = 32'h0,
  parameter logic [31:0] SCRATCH_RESET = 32'h0,
  parameter int CNT_W = 48,
  parameter int ADDR_W = 4,
  parameter int NUM_INFO = 4,
  parameter logic [NUM_INFO*32-1:0] INFO_INIT = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);
  if (CNT_W < 33 || CNT_W > 64 || NUM_INFO < 0 || NUM_INFO > (1 << ADDR_W) - 8) begin : g_bad_param
    $error("niosii_system_sysid_ext: CNT_W or NUM_INFO out of range");
  end
  logic [31:0] a;
  logic [31:0] scratch_q, scratch_d, rdata_q, rdata_d, hi_q, hi_d, rd_mux;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic en_q, en_d, rvalid_q, rvalid_d, rd_ok, wr_ctl;
  assign a = 32'(address);
  assign rd_ok = read && !write;
  assign wr_ctl = write && a == 32'd6 && byteenable[0];
  always_comb begin
    rd_mux = a == 32'd0 ? ID_VALUE :
             a == 32'd1 ? TIMESTAMP :
             a == 32'd2 ? scratch_q :
             a == 32'd3 ? {16'(NUM_INFO), 8'(CNT_W), 8'h02} :
             a == 32'd4 ? cnt_q[31:0] :
             a == 32'd5 ? hi_q :
             a == 32'd6 ? {31'b0, en_q} : 32'h0;
    for (int k = 0; k < NUM_INFO; k++)
      if (a == 32'(8 + k)) rd_mux = INFO_INIT[32*k +: 32];
  end
  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++)
      scratch_d[8*i +: 8] = (write && a == 32'd2 && byteenable[i]) ? writedata[8*i +: 8] : scratch_q[8*i +: 8];
    en_d = wr_ctl ? writedata[0] : en_q;
    // CLR beats increment; a new EN only gates counting from the next cycle
    cnt_d = (wr_ctl && writedata[1]) ? '0 : cnt_q + CNT_W'(en_q);
    hi_d = (rd_ok && a == 32'd4) ? 32'(cnt_q[CNT_W-1:32]) : hi_q;
    rvalid_d = rd_ok;
    rdata_d = rd_ok ? rd_mux : rdata_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= SCRATCH_RESET;
      cnt_q <= '0;
      en_q <= 1'b1;
      hi_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      hi_q <= hi_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
  assign readdata = rdata_q;
  assign readdatavalid = rvalid_q;
endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// tb_niosii_system_sysid_ext: directed bench with a per-cycle behavioural model of the sysid slave
module tb_niosii_system_sysid_ext;
  localparam logic [31:0] ID = 32'h1234_5678;
  localparam logic [31:0] TS = 32'h6543_2100;
  localparam logic [31:0] SR = 32'hA5A5_0000;
  localparam logic [127:0] INFO = {32'h4, 32'h3, 32'h2, 32'h1};
  logic clock = 0, reset = 1, read = 0, write = 0;
  logic [3:0] address = 0, byteenable = 0;
  logic [31:0] writedata = 0, readdata;
  logic readdatavalid;
  niosii_system_sysid_ext #(
    .ID_VALUE(ID), .TIMESTAMP(TS), .SCRATCH_RESET(SR),
    .CNT_W(48), .ADDR_W(4), .NUM_INFO(4), .INFO_INIT(INFO)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid)
  );
  always #5 clock = ~clock;
  int n_pass = 0, n_total = 0;
  bit live = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // model state: what the slave must hold, derived from the register map rules
  logic [31:0] m_scr, m_hi, m_d;
  logic [47:0] m_cnt;
  logic m_en, m_v, m_nen, m_clr;
  logic [31:0] info_w [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
  function automatic logic [31:0] m_read(input logic [3:0] ad);
    case (ad)
      4'd0: return ID;
      4'd1: return TS;
      4'd2: return m_scr;
      4'd3: return {16'd4, 8'd48, 8'h02};
      4'd4: return m_cnt[31:0];
      4'd5: return m_hi;
      4'd6: return {31'b0, m_en};
      4'd8, 4'd9, 4'd10, 4'd11: return info_w[ad - 4'd8];
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      m_v = 0; m_d = 0; m_scr = SR; m_cnt = 0; m_en = 1; m_hi = 0; live = 1;
    end else begin
      m_v = read && !write;
      if (m_v) m_d = m_read(address);
      if (m_v && address == 4'd4) m_hi = 32'(m_cnt >> 32);
      if (write && address == 4'd2)
        for (int i = 0; i < 4; i++) if (byteenable[i]) m_scr[8*i +: 8] = writedata[8*i +: 8];
      m_clr = write && address == 4'd6 && byteenable[0] && writedata[1];
      m_nen = (write && address == 4'd6 && byteenable[0]) ? writedata[0] : m_en;
      m_cnt = m_clr ? 48'd0 : m_en ? m_cnt + 48'd1 : m_cnt;
      m_en = m_nen;
    end
  end
  always @(negedge clock) if (live) begin
    chk("rdv_model", readdatavalid, m_v);
    chk("rdata_model", readdata, m_d);
  end
  task automatic rd(input logic [3:0] ad, output logic [31:0] d);
    address = ad; read = 1;
    @(negedge clock);
    chk("rdv_lit", readdatavalid, 1'b1);
    d = readdata; read = 0;
  endtask
  task automatic wr(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    address = ad; writedata = d; byteenable = be; write = 1;
    @(negedge clock);
    write = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  logic [31:0] d, d2;
  initial begin
    repeat (2) @(negedge clock);
    chk("reset_rdata", readdata, 32'h0);
    chk("reset_rdv", readdatavalid, 1'b0);
    reset = 0;
    rd(4'd0, d); chk("id", d, ID);
    rd(4'd1, d); chk("timestamp", d, TS);
    rd(4'd3, d); chk("caps", d, 32'h0004_3002);
    @(negedge clock);
    rd(4'd2, d); chk("scratch_reset", d, SR);
    wr(4'd2, 32'hDEADBEEF, 4'hF);
    wr(4'd2, 32'h00000011, 4'h1);
    rd(4'd2, d); chk("scratch_be", d, 32'hDEADBE11);
    address = 4'd2; writedata = 32'h0000CAFE; byteenable = 4'h3; write = 1; read = 1;
    @(negedge clock);
    chk("rd_wr_drop", readdatavalid, 1'b0);
    read = 0; write = 0;
    rd(4'd2, d); chk("scratch_rdwr", d, 32'hDEADCAFE);
    wr(4'd6, 32'h0, 4'h1);
    rd(4'd4, d);
    repeat (10) @(negedge clock);
    rd(4'd4, d2); chk("frozen", d2, d);
    wr(4'd6, 32'h3, 4'h1);
    rd(4'd4, d); chk("clr_lo", d, 32'h0);
    rd(4'd6, d); chk("control", d, 32'h1);
    rd(4'd4, d); chk("resume_lo", d, 32'h2);
    wr(4'd6, 32'h0, 4'h1);
    force dut.cnt_q = 48'hFFFF_FFFF;
    m_cnt = 48'hFFFF_FFFF;
    @(negedge clock);
    wr(4'd6, 32'h1, 4'h1);
    release dut.cnt_q;
    rd(4'd4, d); chk("carry_lo", d, 32'hFFFF_FFFF);
    repeat (5) @(negedge clock);
    rd(4'd5, d); chk("carry_hi_pre", d, 32'h0);
    rd(4'd4, d);
    rd(4'd5, d); chk("carry_hi_post", d, 32'h1);
    for (int k = 0; k < 4; k++) begin
      rd(4'(8 + k), d); chk("info", d, 32'(k + 1));
    end
    wr(4'd7, 32'hFFFF_FFFF, 4'hF);
    wr(4'd12, 32'hFFFF_FFFF, 4'hF);
    wr(4'd15, 32'hFFFF_FFFF, 4'hF);
    rd(4'd7, d); chk("unmapped7", d, 32'h0);
    rd(4'd12, d); chk("unmapped12", d, 32'h0);
    rd(4'd15, d); chk("unmapped15", d, 32'h0);
    rd(4'd2, d); chk("scratch_kept", d, 32'hDEADCAFE);
    address = 4'd0; read = 1; reset = 1;
    @(negedge clock);
    chk("reset_cancel_rdv", readdatavalid, 1'b0);
    read = 0; reset = 0;
    rd(4'd5, d); chk("reset_hi", d, 32'h0);
    rd(4'd4, d); chk("reset_lo", d, 32'h1);
    rd(4'd6, d); chk("reset_en", d, 32'h1);
    rd(4'd2, d); chk("reset_scratch", d, SR);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
